mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_if.sv | 46 ++++
 rtl/mem_access_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the core-side request/response signals and the
// SDRAM-side read/write channels used by mem_access_unit.
//   slave  : view of mem_access_unit (core requests in, SDRAM requests out)
//   master : view of the environment (core requester + SDRAM model)
// Core side : mem_wr_req, mem_rd_req, funct3, mem_addr, mem_wr_data ->
//             mem_rd_data, mem_wr_fin, mem_rd_fin, mem_err
// SDRAM side: sdram_rd_req/addr -> sdram_rd_data/fin,
//             sdram_wr_req/addr/data -> sdram_wr_fin
interface mem_access_unit_if;
    logic        mem_wr_req;
    logic        mem_rd_req;
    logic [2:0]  funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_wr_fin;
    logic        mem_rd_fin;
    logic        mem_err;

    logic        sdram_rd_req;
    logic [31:0] sdram_rd_addr;
    logic [31:0] sdram_rd_data;
    logic        sdram_rd_fin;
    logic        sdram_wr_req;
    logic [31:0] sdram_wr_addr;
    logic [31:0] sdram_wr_data;
    logic        sdram_wr_fin;

    modport slave (
        input  mem_wr_req, mem_rd_req, funct3, mem_addr, mem_wr_data,
        output mem_rd_data, mem_wr_fin, mem_rd_fin, mem_err,
        output sdram_rd_req, sdram_rd_addr,
        input  sdram_rd_data, sdram_rd_fin,
        output sdram_wr_req, sdram_wr_addr, sdram_wr_data,
        input  sdram_wr_fin
    );

    modport master (
        output mem_wr_req, mem_rd_req, funct3, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_wr_fin, mem_rd_fin, mem_err,
        input  sdram_rd_req, sdram_rd_addr,
        output sdram_rd_data, sdram_rd_fin,
        input  sdram_wr_req, sdram_wr_addr, sdram_wr_data,
        output sdram_wr_fin
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage between the execution core and a single-port
// SDRAM. Converts RV32 byte/half/word loads and stores into word-aligned SDRAM
// transactions; sub-word stores use read-modify-write. Loads return a
// sign/zero-extended result together with a one-cycle completion pulse.
//
// Ports:
//   clk     : clock
//   reset   : asynchronous, active-high reset
//   io_bus  : mem_access_unit_if.slave (core request/response + SDRAM channels)
//
// Parameters:
//   TIMEOUT : max cycles to wait for one SDRAM ack; 0 disables the watchdog.
//
// Build option:
//   MEM_MISALIGN_TRAP_EN : when defined, misaligned H/W accesses complete
//   immediately with mem_err=1 and no SDRAM activity. When undefined, the low
//   address bits below the access size are ignored.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  reset,
    mem_access_unit_if.slave     io_bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLd,
        StRmwRd,
        StSt,
        StDone
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr,     w_addr_next;
    logic [31:0] r_wdata,    w_wdata_next;
    logic [2:0]  r_funct3,   w_funct3_next;
    logic        r_is_store, w_is_store_next;
    logic [31:0] r_rd_data,  w_rd_data_next;
    logic        r_err,      w_err_next;
    logic [31:0] r_wdog,     w_wdog_next;

    logic        w_timeout;
    logic        w_misalign;

    // funct3[1:0] selects size; funct3[2] selects zero-extension.
    function automatic logic f_is_byte(input logic [2:0] f3);
        return f3 == 3'b000 || f3 == 3'b100;
    endfunction

    function automatic logic f_is_half(input logic [2:0] f3);
        return f3 == 3'b001 || f3 == 3'b101;
    endfunction

    function automatic logic [31:0] f_load_extend(input logic [31:0] word,
                                                  input logic [1:0]  lo,
                                                  input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        if (f_is_byte(f3)) begin
            return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
        end else if (f_is_half(f3)) begin
            return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
        end
        return word;
    endfunction

    function automatic logic [31:0] f_store_merge(input logic [31:0] old_word,
                                                  input logic [31:0] new_data,
                                                  input logic [1:0]  lo,
                                                  input logic [2:0]  f3);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] lane;
        sh   = 5'd0;
        mask = 32'hFFFF_FFFF;
        lane = new_data;
        if (f_is_byte(f3)) begin
            sh   = {lo, 3'b000};
            mask = 32'h0000_00FF << sh;
            lane = {24'b0, new_data[7:0]} << sh;
        end else if (f_is_half(f3)) begin
            sh   = {lo[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
            lane = {16'b0, new_data[15:0]} << sh;
        end
        return (old_word & ~mask) | lane;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    // Anything not B/H is a word access, including reserved funct3 codes.
    assign w_misalign = (f_is_half(io_bus.funct3) && io_bus.mem_addr[0]) ||
                        (!f_is_half(io_bus.funct3) && !f_is_byte(io_bus.funct3) &&
                         io_bus.mem_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Fires on the last allowed wait cycle, so the SDRAM req is high for
    // exactly TIMEOUT cycles.
    assign w_timeout = (TIMEOUT != 0) && (r_wdog == 32'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_is_store <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_wdog     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_funct3   <= w_funct3_next;
            r_is_store <= w_is_store_next;
            r_rd_data  <= w_rd_data_next;
            r_err      <= w_err_next;
            r_wdog     <= w_wdog_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_wdata_next    = r_wdata;
        w_funct3_next   = r_funct3;
        w_is_store_next = r_is_store;
        w_rd_data_next  = r_rd_data;
        w_err_next      = r_err;
        w_wdog_next     = '0;

        unique case (r_state)
            StIdle: begin
                if (io_bus.mem_wr_req || io_bus.mem_rd_req) begin
                    // Store wins when both requests are high.
                    w_addr_next     = io_bus.mem_addr;
                    w_funct3_next   = io_bus.funct3;
                    w_is_store_next = io_bus.mem_wr_req;
                    w_wdata_next    = io_bus.mem_wr_data;
                    w_err_next      = 1'b0;
                    if (w_misalign) begin
                        w_err_next   = 1'b1;
                        w_state_next = StDone;
                    end else if (!io_bus.mem_wr_req) begin
                        w_state_next = StLd;
                    end else if (f_is_byte(io_bus.funct3) || f_is_half(io_bus.funct3)) begin
                        w_state_next = StRmwRd;
                    end else begin
                        w_state_next = StSt;
                    end
                end
            end
            StLd: begin
                if (io_bus.sdram_rd_fin) begin
                    w_rd_data_next = f_load_extend(io_bus.sdram_rd_data, r_addr[1:0], r_funct3);
                    w_state_next   = StDone;
                end else if (w_timeout) begin
                    w_err_next   = 1'b1;
                    w_state_next = StDone;
                end else begin
                    w_wdog_next = r_wdog + 32'd1;
                end
            end
            StRmwRd: begin
                if (io_bus.sdram_rd_fin) begin
                    w_wdata_next = f_store_merge(io_bus.sdram_rd_data, r_wdata,
                                                 r_addr[1:0], r_funct3);
                    w_state_next = StSt;
                end else if (w_timeout) begin
                    w_err_next   = 1'b1;
                    w_state_next = StDone;
                end else begin
                    w_wdog_next = r_wdog + 32'd1;
                end
            end
            StSt: begin
                if (io_bus.sdram_wr_fin) begin
                    w_state_next = StDone;
                end else if (w_timeout) begin
                    w_err_next   = 1'b1;
                    w_state_next = StDone;
                end else begin
                    w_wdog_next = r_wdog + 32'd1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs decode straight from the state register so a reset drops the
    // SDRAM requests without waiting for a clock edge.
    always_comb begin
        io_bus.sdram_rd_req  = (r_state == StLd) || (r_state == StRmwRd);
        io_bus.sdram_wr_req  = (r_state == StSt);
        io_bus.sdram_rd_addr = {r_addr[31:2], 2'b00};
        io_bus.sdram_wr_addr = {r_addr[31:2], 2'b00};
        io_bus.sdram_wr_data = r_wdata;
        io_bus.mem_wr_fin    = (r_state == StDone) && r_is_store;
        io_bus.mem_rd_fin    = (r_state == StDone) && !r_is_store;
        io_bus.mem_err       = r_err;
        io_bus.mem_rd_data   = r_rd_data;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .TIMEOUT(16)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus)
    );

    // SDRAM model: ack on the LAT-th cycle of a held request.
    int          lat = 3;
    logic        ack_en = 1'b1;
    logic [31:0] mem [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cycles = 0;
    int          wr_count = 0;
    logic        overlap = 1'b0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt            <= 0;
            wr_cnt            <= 0;
            bus.sdram_rd_fin  <= 1'b0;
            bus.sdram_wr_fin  <= 1'b0;
            bus.sdram_rd_data <= '0;
        end else begin
            if (bus.sdram_rd_req && bus.sdram_wr_req) overlap <= 1'b1;
            if (bus.sdram_rd_req) rd_cycles <= rd_cycles + 1;
            if (!bus.sdram_rd_req || bus.sdram_rd_fin || !ack_en) begin
                rd_cnt           <= 0;
                bus.sdram_rd_fin <= 1'b0;
            end else begin
                rd_cnt <= rd_cnt + 1;
                if (rd_cnt + 1 == lat - 1) begin
                    bus.sdram_rd_fin  <= 1'b1;
                    bus.sdram_rd_data <= mem[bus.sdram_rd_addr[9:2]];
                end
            end
            if (!bus.sdram_wr_req || bus.sdram_wr_fin || !ack_en) begin
                wr_cnt           <= 0;
                bus.sdram_wr_fin <= 1'b0;
            end else begin
                wr_cnt <= wr_cnt + 1;
                if (wr_cnt + 1 == lat - 1) begin
                    bus.sdram_wr_fin <= 1'b1;
                    wr_count         <= wr_count + 1;
                    last_wr_addr     <= bus.sdram_wr_addr;
                    last_wr_data     <= bus.sdram_wr_data;
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Runs one access; cyc is the cycle number (req rises in cycle 1) where fin shows.
    task automatic do_op(input string tag, input logic is_store, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         output int cyc, output logic err, output logic [31:0] rdata);
        logic done;
        done = 1'b0;
        cyc  = 1;
        @(negedge clk);
        bus.funct3      = f3;
        bus.mem_addr    = addr;
        bus.mem_wr_data = data;
        bus.mem_wr_req  = is_store;
        bus.mem_rd_req  = !is_store;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (is_store ? bus.mem_wr_fin : bus.mem_rd_fin) done = 1'b1;
        end
        err   = bus.mem_err;
        rdata = bus.mem_rd_data;
        bus.mem_wr_req = 1'b0;
        bus.mem_rd_req = 1'b0;
        check({tag, "_fin_seen"}, {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_fin_pulse"}, {30'b0, bus.mem_wr_fin, bus.mem_rd_fin}, 32'd0);
    endtask

    int          cyc;
    logic        err;
    logic [31:0] rdata;
    int          rd_before;
    int          wr_before;
    logic        got_wr;
    logic        order_bad;
    logic        fin_seen;

    initial begin
        bus.mem_wr_req  = 1'b0;
        bus.mem_rd_req  = 1'b0;
        bus.funct3      = 3'b010;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_req", {31'b0, bus.sdram_rd_req}, 32'd0);
        check("rst_wr_req", {31'b0, bus.sdram_wr_req}, 32'd0);
        check("rst_fins", {30'b0, bus.mem_wr_fin, bus.mem_rd_fin}, 32'd0);
        check("rst_err", {31'b0, bus.mem_err}, 32'd0);
        check("rst_rd_data", bus.mem_rd_data, 32'd0);
        check("rst_wr_data", bus.sdram_wr_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // SW: single write, no read, fin at cycle L+2.
        rd_before = rd_cycles;
        wr_before = wr_count;
        do_op("sw", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, cyc, err, rdata);
        check("sw_cycle", cyc, 32'd5);
        check("sw_wr_count", wr_count - wr_before, 32'd1);
        check("sw_wr_addr", last_wr_addr, 32'h100);
        check("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);
        check("sw_no_read", rd_cycles - rd_before, 32'd0);
        check("sw_err", {31'b0, err}, 32'd0);

        // SB: read-modify-write of byte 2.
        mem[64] = 32'h1122_3344;
        rd_before = rd_cycles;
        do_op("sb", 1'b1, 3'b000, 32'h102, 32'h0000_00AB, cyc, err, rdata);
        check("sb_read_cycles", rd_cycles - rd_before, 32'd3);
        check("sb_wr_addr", last_wr_addr, 32'h100);
        check("sb_wr_data", last_wr_data, 32'h11AB_3344);

        // SH upper half.
        mem[64] = 32'h1122_3344;
        do_op("sh", 1'b1, 3'b001, 32'h102, 32'hFFFF_BEEF, cyc, err, rdata);
        check("sh_wr_data", last_wr_data, 32'hBEEF_3344);

        // Loads from 0x80FF0000.
        mem[64] = 32'h80FF_0000;
        do_op("lw", 1'b0, 3'b010, 32'h100, 32'h0, cyc, err, rdata);
        check("lw_data", rdata, 32'h80FF_0000);
        check("lw_cycle", cyc, 32'd5);
        do_op("lb", 1'b0, 3'b000, 32'h103, 32'h0, cyc, err, rdata);
        check("lb_data", rdata, 32'hFFFF_FF80);
        do_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, cyc, err, rdata);
        check("lbu_data", rdata, 32'h0000_0080);
        do_op("lh", 1'b0, 3'b001, 32'h102, 32'h0, cyc, err, rdata);
        check("lh_data", rdata, 32'hFFFF_80FF);
        do_op("lhu", 1'b0, 3'b101, 32'h100, 32'h0, cyc, err, rdata);
        check("lhu_data", rdata, 32'h0000_0000);

        // Simultaneous store and load: store first, then the load.
        mem[65] = 32'h0A0B_0C0D;
        got_wr    = 1'b0;
        order_bad = 1'b0;
        fin_seen  = 1'b0;
        @(negedge clk);
        bus.funct3      = 3'b010;
        bus.mem_addr    = 32'h200;
        bus.mem_wr_data = 32'h1234_5678;
        bus.mem_wr_req  = 1'b1;
        bus.mem_rd_req  = 1'b1;
        for (int i = 0; i < 200 && !fin_seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_rd_fin) begin
                fin_seen = 1'b1;
                if (!got_wr) order_bad = 1'b1;
                rdata = bus.mem_rd_data;
                bus.mem_rd_req = 1'b0;
            end
            if (bus.mem_wr_fin) begin
                got_wr = 1'b1;
                bus.mem_wr_req = 1'b0;
                bus.mem_addr   = 32'h104;
            end
        end
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        check("both_rd_fin", {31'b0, fin_seen}, 32'd1);
        check("both_order", {30'b0, got_wr, order_bad}, 32'd2);
        check("both_wr_addr", last_wr_addr, 32'h200);
        check("both_wr_data", last_wr_data, 32'h1234_5678);
        check("both_rd_data", rdata, 32'h0A0B_0C0D);
        check("both_overlap", {31'b0, overlap}, 32'd0);
        @(posedge clk);

        // Watchdog: no ack for an LW.
        ack_en = 1'b0;
        rd_before = rd_cycles;
        do_op("to", 1'b0, 3'b010, 32'h100, 32'h0, cyc, err, rdata);
        check("to_err", {31'b0, err}, 32'd1);
        check("to_req_cycles", rd_cycles - rd_before, 32'd16);
        check("to_cycle", cyc, 32'd18);
        ack_en = 1'b1;
        do_op("rec", 1'b0, 3'b010, 32'h100, 32'h0, cyc, err, rdata);
        check("rec_err_cleared", {31'b0, err}, 32'd0);
        check("rec_data", rdata, 32'h80FF_0000);

        // Misaligned LW.
        mem[64] = 32'hCAFE_F00D;
        rd_before = rd_cycles;
        do_op("mis", 1'b0, 3'b010, 32'h101, 32'h0, cyc, err, rdata);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_err", {31'b0, err}, 32'd1);
        check("mis_cycle", cyc, 32'd2);
        check("mis_no_read", rd_cycles - rd_before, 32'd0);
        check("mis_data_held", rdata, 32'h80FF_0000);
`else
        check("mis_err", {31'b0, err}, 32'd0);
        check("mis_data", rdata, 32'hCAFE_F00D);
        check("mis_cycle", cyc, 32'd5);
`endif

        // Reset in the middle of an SB read phase.
        ack_en = 1'b0;
        wr_before = wr_count;
        @(negedge clk);
        bus.funct3      = 3'b000;
        bus.mem_addr    = 32'h100;
        bus.mem_wr_data = 32'h55;
        bus.mem_wr_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rmw_rd_req_up", {31'b0, bus.sdram_rd_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rmw_rst_reqs", {30'b0, bus.sdram_rd_req, bus.sdram_wr_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_wr_req = 1'b0;
        ack_en = 1'b1;
        fin_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_wr_fin || bus.mem_rd_fin || bus.sdram_wr_req) fin_seen = 1'b1;
        end
        check("rmw_rst_no_fin", {31'b0, fin_seen}, 32'd0);
        check("rmw_rst_no_write", wr_count - wr_before, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
